// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two writeback requesters (A = ALU, B = memory load) each own a one-deep
// holding slot. The single registered write port is granted oldest-first,
// with a round-robin pointer breaking ties between slots loaded together.
// A pending-write scoreboard covers both slots and the write being presented,
// so decode can stall on RAW hazards.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_reg,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_reg,
  input  logic [DATA_W-1:0]        b_data,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     last_b
);

  localparam int NUM_REGS = 1 << ADDR_W;

  // Slot state. older_x marks that slot x was already waiting when the other
  // slot was loaded, i.e. slot x holds the older of the two writes.
  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_reg_q, b_reg_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  logic              older_a, older_b;

  logic grant_a, grant_b;
  logic load_a, load_b;

  // Grant is derived purely from registered slot state so ready never
  // depends combinationally on valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && !b_full) begin
      grant_a = 1'b1;
    end else if (b_full && !a_full) begin
      grant_b = 1'b1;
    end else if (a_full && b_full) begin
      if (older_a) begin
        grant_a = 1'b1;
      end else if (older_b) begin
        grant_b = 1'b1;
      end else if (last_b) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end
  end

  // Handshake: a slot accepts when empty or when it is being drained this
  // cycle. Writes to r0 are accepted but never occupy the slot.
  always_comb begin
    a_ready = !a_full || grant_a;
    b_ready = !b_full || grant_b;
    load_a  = a_valid && a_ready && (a_reg != '0);
    load_b  = b_valid && b_ready && (b_reg != '0);
  end

  // Slot contents, age tracking, round-robin pointer and the output register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_full    <= 1'b0;
      b_full    <= 1'b0;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      older_a   <= 1'b0;
      older_b   <= 1'b0;
      last_b    <= 1'b1;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      if (load_a) begin
        a_full   <= 1'b1;
        a_reg_q  <= a_reg;
        a_data_q <= a_data;
      end else if (grant_a) begin
        a_full   <= 1'b0;
      end

      if (load_b) begin
        b_full   <= 1'b1;
        b_reg_q  <= b_reg;
        b_data_q <= b_data;
      end else if (grant_b) begin
        b_full   <= 1'b0;
      end

      if (grant_a || load_a) begin
        older_a <= 1'b0;
      end else if (load_b && a_full) begin
        older_a <= 1'b1;
      end

      if (grant_b || load_b) begin
        older_b <= 1'b0;
      end else if (load_a && b_full) begin
        older_b <= 1'b1;
      end

      if (grant_a) begin
        writeReg  <= a_reg_q;
        writeData <= a_data_q;
        last_b    <= 1'b0;
      end else if (grant_b) begin
        writeReg  <= b_reg_q;
        writeData <= b_data_q;
        last_b    <= 1'b1;
      end else begin
        writeReg  <= '0;
      end
    end
  end

  // Scoreboard: every register with a write still queued or on the port.
  always_comb begin
    pending = '0;
    if (a_full) pending[a_reg_q] = 1'b1;
    if (b_full) pending[b_reg_q] = 1'b1;
    pending[writeReg] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule
